// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the common word/address types, the fetch/decode pipeline view and
// the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int          ADDR_W_DEF   = 64;
    localparam logic [63:0] PC_RESET_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef logic [31:0] word_t;
    typedef logic [63:0] addr_t;

    // Fetch FSM: idle, request presented on the bus, waiting for data.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Decode-facing view of the fetch/decode pipeline register.
    typedef struct packed {
        logic  valid;
        logic  exc;
        addr_t pc;
        word_t instr;
    } fetch_decode_t;

    // A fetch address is misaligned when it is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_pcsel.sv
// Next-PC selection for the fetch stage (purely combinational).
// A redirect always wins; a completed, non-discarded fetch advances by 4
// (wrapping modulo 2^ADDR_W); otherwise the PC holds.
module fetch_pcsel #(
    parameter int ADDR_W = 64
) (
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_complete,
    input  logic              i_discard,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_next_pc
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

    // Pick the next PC from redirect, sequential advance or hold.
    always_comb begin
        o_next_pc = i_pc;
        if (i_redirect_valid) begin
            o_next_pc = i_redirect_pc;
        end else if (i_complete && !i_discard) begin
            o_next_pc = i_pc + PC_STEP;
        end else begin
            o_next_pc = i_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-bus
// request outstanding and fills the fetch/decode register consumed by decode.
// Redirects from execute beat decode stalls and returning data; a response
// to a request that was overtaken by a redirect is dropped via r_discard.
// Optional build macro FETCH_MISALIGN_EN: a misaligned PC raises a fetch
// exception (nop + fd_exc) instead of going out on the bus, and fetch then
// parks until the next redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEF)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ireq_valid,
    output logic [ADDR_W-1:0] ireq_addr,
    input  logic              iresp_addr_ok,
    input  logic              iresp_data_ok,
    input  logic [31:0]       iresp_data,
    output logic              fd_valid,
    output logic [ADDR_W-1:0] fd_pc,
    output logic [31:0]       fd_instr,
    output logic              fd_exc
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_discard;
    logic              w_discard_nxt;
    logic              r_ireq_valid;
    logic              w_ireq_valid_nxt;
    logic [ADDR_W-1:0] r_ireq_addr;
    logic [ADDR_W-1:0] w_ireq_addr_nxt;
    logic              r_fd_valid;
    logic              w_fd_valid_nxt;
    logic [ADDR_W-1:0] r_fd_pc;
    logic [ADDR_W-1:0] w_fd_pc_nxt;
    logic [31:0]       r_fd_instr;
    logic [31:0]       w_fd_instr_nxt;

    logic              w_slot_free;
    logic              w_consume;
    logic              w_complete;
    logic              w_misalign_chk;
    logic              w_fetch_en;
    logic              w_misalign_hit;

    assign ireq_valid = r_ireq_valid;
    assign ireq_addr  = r_ireq_addr;
    assign fd_valid   = r_fd_valid;
    assign fd_pc      = r_fd_pc;
    assign fd_instr   = r_fd_instr;

`ifdef FETCH_MISALIGN_EN
    logic r_fd_exc;
    logic r_halt;

    assign w_misalign_chk = is_misaligned(r_pc[1:0]);
    assign w_fetch_en     = !r_halt;
    assign fd_exc         = r_fd_exc;

    // Exception flag follows the slot; park flag holds fetch until a redirect.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fd_exc <= 1'b0;
            r_halt   <= 1'b0;
        end else begin
            if (redirect_valid || w_complete) begin
                r_fd_exc <= 1'b0;
            end else if (w_misalign_hit) begin
                r_fd_exc <= 1'b1;
            end else if (w_consume) begin
                r_fd_exc <= 1'b0;
            end else begin
                r_fd_exc <= r_fd_exc;
            end

            if (redirect_valid) begin
                r_halt <= 1'b0;
            end else if (w_misalign_hit) begin
                r_halt <= 1'b1;
            end else begin
                r_halt <= r_halt;
            end
        end
    end
`else
    assign w_misalign_chk = 1'b0;
    assign w_fetch_en     = 1'b1;
    assign fd_exc         = 1'b0;
`endif

    // Slot occupancy and bus completion qualifiers.
    always_comb begin
        w_slot_free = !r_fd_valid || !stall;
        w_consume   = r_fd_valid && !stall;
        w_complete  = ((r_state == REQ) && iresp_addr_ok && iresp_data_ok) ||
                      ((r_state == WAIT) && iresp_data_ok);
    end

    fetch_pcsel #(
        .ADDR_W(ADDR_W)
    ) u_pcsel (
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .i_complete      (w_complete),
        .i_discard       (r_discard),
        .i_pc            (r_pc),
        .o_next_pc       (w_pc_nxt)
    );

    // Fetch FSM next state, bus request and discard tracking.
    always_comb begin
        w_state_nxt      = r_state;
        w_ireq_valid_nxt = r_ireq_valid;
        w_ireq_addr_nxt  = r_ireq_addr;
        w_discard_nxt    = r_discard;
        w_misalign_hit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (redirect_valid) begin
                    w_state_nxt = IDLE;
                end else if (w_slot_free && w_fetch_en) begin
                    if (w_misalign_chk) begin
                        w_misalign_hit = 1'b1;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_state_nxt      = REQ;
                        w_ireq_valid_nxt = 1'b1;
                        w_ireq_addr_nxt  = r_pc;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (iresp_addr_ok) begin
                    w_ireq_valid_nxt = 1'b0;
                    w_state_nxt      = iresp_data_ok ? IDLE : WAIT;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            WAIT: begin
                if (iresp_data_ok) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_ireq_valid_nxt = 1'b0;
            end
        endcase

        if (w_complete) begin
            w_discard_nxt = 1'b0;
        end else if (redirect_valid && (r_state != IDLE)) begin
            w_discard_nxt = 1'b1;
        end else begin
            w_discard_nxt = r_discard;
        end
    end

    // Fetch/decode register next value: redirect > completion > exception > consume.
    always_comb begin
        w_fd_valid_nxt = r_fd_valid;
        w_fd_pc_nxt    = r_fd_pc;
        w_fd_instr_nxt = r_fd_instr;
        if (redirect_valid) begin
            w_fd_valid_nxt = 1'b0;
        end else if (w_complete && !r_discard) begin
            w_fd_valid_nxt = 1'b1;
            w_fd_pc_nxt    = r_pc;
            w_fd_instr_nxt = iresp_data;
        end else if (w_complete) begin
            w_fd_valid_nxt = 1'b0;
        end else if (w_misalign_hit) begin
            w_fd_valid_nxt = 1'b1;
            w_fd_pc_nxt    = r_pc;
            w_fd_instr_nxt = NOP_INSTR;
        end else if (w_consume) begin
            w_fd_valid_nxt = 1'b0;
        end else begin
            w_fd_valid_nxt = r_fd_valid;
        end
    end

    // State, PC, bus request and fetch/decode registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_pc         <= PC_RESET;
            r_discard    <= 1'b0;
            r_ireq_valid <= 1'b0;
            r_ireq_addr  <= {ADDR_W{1'b0}};
            r_fd_valid   <= 1'b0;
            r_fd_pc      <= {ADDR_W{1'b0}};
            r_fd_instr   <= 32'h0000_0000;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_discard    <= w_discard_nxt;
            r_ireq_valid <= w_ireq_valid_nxt;
            r_ireq_addr  <= w_ireq_addr_nxt;
            r_fd_valid   <= w_fd_valid_nxt;
            r_fd_pc      <= w_fd_pc_nxt;
            r_fd_instr   <= w_fd_instr_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point.
module tb_fetch_unit;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        fd_valid;
    logic [63:0] fd_pc;
    logic [31:0] fd_instr;
    logic        fd_exc;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit dut (
        .clk           (clk),
        .resetn        (resetn),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .fd_valid      (fd_valid),
        .fd_pc         (fd_pc),
        .fd_instr      (fd_instr),
        .fd_exc        (fd_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'h0000_0000;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; stall = 1'b0; redirect_pc = 64'h0;
        clear_bus();
        tick(); tick();
        n_checks++; if (ireq_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ireq_valid got %0b exp 0", ireq_valid); end
        n_checks++; if (ireq_addr !== 64'h0) begin n_errors++; $display("FAIL reset_ireq_addr got %h exp 0", ireq_addr); end
        n_checks++; if (fd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fd_valid got %0b exp 0", fd_valid); end
        n_checks++; if (fd_pc !== 64'h0) begin n_errors++; $display("FAIL reset_fd_pc got %h exp 0", fd_pc); end
        n_checks++; if (fd_instr !== 32'h0) begin n_errors++; $display("FAIL reset_fd_instr got %h exp 0", fd_instr); end
        n_checks++; if (fd_exc !== 1'b0) begin n_errors++; $display("FAIL reset_fd_exc got %0b exp 0", fd_exc); end
        resetn = 1'b1;
    endtask

    task automatic test_basic_fetch();
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin n_errors++; $display("FAIL first_req got v=%0b a=%h exp v=1 a=80000000", ireq_valid, ireq_addr); end
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0000_0513;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b1 || fd_pc !== 64'h8000_0000 || fd_instr !== 32'h0000_0513) begin n_errors++; $display("FAIL first_fd got v=%0b pc=%h i=%h exp v=1 pc=80000000 i=00000513", fd_valid, fd_pc, fd_instr); end
        n_checks++; if (ireq_valid !== 1'b0) begin n_errors++; $display("FAIL first_req_drop got %0b exp 0", ireq_valid); end
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004 || fd_valid !== 1'b0) begin n_errors++; $display("FAIL second_req got v=%0b a=%h fdv=%0b exp v=1 a=80000004 fdv=0", ireq_valid, ireq_addr, fd_valid); end
    endtask

    task automatic test_stall();
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h00A0_0593; stall = 1'b1;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b1 || fd_pc !== 64'h8000_0004) begin n_errors++; $display("FAIL stall_load got v=%0b pc=%h exp v=1 pc=80000004", fd_valid, fd_pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (ireq_valid !== 1'b0) begin n_errors++; $display("FAIL stall_no_req cyc %0d got %0b exp 0", i, ireq_valid); end
            n_checks++; if (fd_valid !== 1'b1 || fd_pc !== 64'h8000_0004 || fd_instr !== 32'h00A0_0593) begin n_errors++; $display("FAIL stall_hold cyc %0d got v=%0b pc=%h i=%h exp v=1 pc=80000004 i=00a00593", i, fd_valid, fd_pc, fd_instr); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008 || fd_valid !== 1'b0) begin n_errors++; $display("FAIL stall_release got v=%0b a=%h fdv=%0b exp v=1 a=80000008 fdv=0", ireq_valid, ireq_addr, fd_valid); end
    endtask

    task automatic test_redirect_wait();
        iresp_addr_ok = 1'b1;
        tick(); clear_bus();
        n_checks++; if (ireq_valid !== 1'b0) begin n_errors++; $display("FAIL wait_entry got %0b exp 0", ireq_valid); end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        tick(); clear_bus();
        n_checks++; if (ireq_valid !== 1'b0 || fd_valid !== 1'b0) begin n_errors++; $display("FAIL wait_redirect got v=%0b fdv=%0b exp 0 0", ireq_valid, fd_valid); end
        iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b0 || fd_instr === 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wait_discard got v=%0b i=%h exp v=0 i!=deadbeef", fd_valid, fd_instr); end
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000) begin n_errors++; $display("FAIL wait_target got v=%0b a=%h exp v=1 a=80001000", ireq_valid, ireq_addr); end
        n_checks++; if (fd_valid !== 1'b0 || fd_instr === 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wait_no_leak got v=%0b i=%h exp v=0 i!=deadbeef", fd_valid, fd_instr); end
    endtask

    task automatic test_redirect_with_data();
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h1111_1111;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_errors++; $display("FAIL same_cyc_drop got fdv=%0b v=%0b exp 0 0", fd_valid, ireq_valid); end
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000) begin n_errors++; $display("FAIL same_cyc_target got v=%0b a=%h exp v=1 a=80002000", ireq_valid, ireq_addr); end
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h2222_2222;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b1 || fd_pc !== 64'h8000_2000 || fd_instr !== 32'h2222_2222) begin n_errors++; $display("FAIL same_cyc_no_discard got v=%0b pc=%h i=%h exp v=1 pc=80002000 i=22222222", fd_valid, fd_pc, fd_instr); end
    endtask

    task automatic test_addr_hold();
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2004) begin n_errors++; $display("FAIL hold_issue got v=%0b a=%h exp v=1 a=80002004", ireq_valid, ireq_addr); end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin redirect_valid = 1'b1; redirect_pc = 64'h8000_3000; end
            tick(); clear_bus();
            n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2004) begin n_errors++; $display("FAIL hold_stable cyc %0d got v=%0b a=%h exp v=1 a=80002004", i, ireq_valid, ireq_addr); end
        end
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h3333_3333;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_errors++; $display("FAIL hold_dropped got fdv=%0b v=%0b exp 0 0", fd_valid, ireq_valid); end
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_3000) begin n_errors++; $display("FAIL hold_target got v=%0b a=%h exp v=1 a=80003000", ireq_valid, ireq_addr); end
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h4444_4444;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b1 || fd_pc !== 64'h8000_3000 || fd_instr !== 32'h4444_4444) begin n_errors++; $display("FAIL hold_fd got v=%0b pc=%h i=%h exp v=1 pc=80003000 i=44444444", fd_valid, fd_pc, fd_instr); end
    endtask

    task automatic test_pc_wrap();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_errors++; $display("FAIL idle_redirect got fdv=%0b v=%0b exp 0 0", fd_valid, ireq_valid); end
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_errors++; $display("FAIL wrap_req got v=%0b a=%h exp v=1 a=fffffffffffffffc", ireq_valid, ireq_addr); end
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h5555_5555;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b1 || fd_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_errors++; $display("FAIL wrap_fd got v=%0b pc=%h exp v=1 pc=fffffffffffffffc", fd_valid, fd_pc); end
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0) begin n_errors++; $display("FAIL wrap_next got v=%0b a=%h exp v=1 a=0", ireq_valid, ireq_addr); end
    endtask

    task automatic test_misalign();
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h6666_6666;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_errors++; $display("FAIL mis_redirect got fdv=%0b v=%0b exp 0 0", fd_valid, ireq_valid); end
        tick();
`ifdef FETCH_MISALIGN_EN
        n_checks++; if (ireq_valid !== 1'b0) begin n_errors++; $display("FAIL mis_no_req got %0b exp 0", ireq_valid); end
        n_checks++; if (fd_valid !== 1'b1 || fd_exc !== 1'b1 || fd_instr !== 32'h0000_0013 || fd_pc !== 64'h8000_0002) begin n_errors++; $display("FAIL mis_exc got v=%0b e=%0b i=%h pc=%h exp v=1 e=1 i=00000013 pc=80000002", fd_valid, fd_exc, fd_instr, fd_pc); end
        tick();
        n_checks++; if (ireq_valid !== 1'b0 || fd_valid !== 1'b0) begin n_errors++; $display("FAIL mis_parked got v=%0b fdv=%0b exp 0 0", ireq_valid, fd_valid); end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0000;
        tick(); clear_bus();
        tick();
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000 || fd_exc !== 1'b0) begin n_errors++; $display("FAIL mis_resume got v=%0b a=%h e=%0b exp v=1 a=80000000 e=0", ireq_valid, ireq_addr, fd_exc); end
`else
        n_checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0002) begin n_errors++; $display("FAIL mis_passthru got v=%0b a=%h exp v=1 a=80000002", ireq_valid, ireq_addr); end
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h7777_7777;
        tick(); clear_bus();
        n_checks++; if (fd_valid !== 1'b1 || fd_exc !== 1'b0 || fd_pc !== 64'h8000_0002) begin n_errors++; $display("FAIL mis_no_exc got v=%0b e=%0b pc=%h exp v=1 e=0 pc=80000002", fd_valid, fd_exc, fd_pc); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_with_data();
        test_addr_hold();
        test_pc_wrap();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of decode.
- Owns the PC and issues one instruction-bus request at a time.
- Presents the fetched {pc, instr} in the fetch/decode pipeline register that decode's operand-select logic consumes.
- Honours decode's bubble (stall) and execute's redirect (branch/jump).

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC value loaded on reset.
- ADDR_W, 64, width of PC and bus address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- stall  input  1  decode bubble; fetch/decode register must hold its contents.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_pc  input  ADDR_W  redirect target.
- ireq_valid  output  1  instruction bus request valid.
- ireq_addr  output  ADDR_W  request address.
- iresp_addr_ok  input  1  bus accepted the address this cycle.
- iresp_data_ok  input  1  instruction data returned this cycle.
- iresp_data  input  32  instruction word.
- fd_valid  output  1  fetch/decode register holds a valid instruction.
- fd_pc  output  ADDR_W  PC of the held instruction.
- fd_instr  output  32  held instruction.
- fd_exc  output  1  misaligned-fetch exception flag; always 0 without FETCH_MISALIGN_EN.

Behaviour:
- Reset (asynchronous, active-low): pc=PC_RESET, state=IDLE, discard=0, ireq_valid=0, ireq_addr=0, fd_valid=0, fd_pc=0, fd_instr=0, fd_exc=0.
- Slot free means !fd_valid || !stall. Decode consumes the register on any cycle with fd_valid && !stall.
- At most one request is outstanding. Only fetch writes the slot, so the slot is empty whenever data returns.
- FSM transitions:
  - IDLE -> REQ when the slot is free and no redirect this cycle. Register ireq_valid=1, ireq_addr=pc.
  - REQ: ireq_valid and ireq_addr stay stable until iresp_addr_ok. Without data_ok -> WAIT. With data_ok in the same cycle -> IDLE (complete).
  - WAIT -> IDLE on iresp_data_ok (complete).
- Complete, with discard=0: fd_valid=1, fd_pc=pc, fd_instr=iresp_data, pc<=pc+4 (wraps modulo 2^ADDR_W).
- Complete, with discard=1: drop the data, clear discard, set fd_valid=0.
- If the slot is consumed with no completion this cycle, fd_valid<=0.
- Redirect priority: redirect beats stall and beats completion data.
  - On redirect_valid: pc<=redirect_pc; fd_valid<=0, including a held or just-arriving instruction.
  - In IDLE: return to IDLE; the next request goes out the following cycle.
  - In REQ or WAIT: set discard=1. The address stays stable in REQ; the request is completed and dropped.
  - Redirect in the same cycle as data_ok: data is discarded immediately and discard is not set.
- Back-to-back redirects: the latest redirect_pc wins; discard stays 1 until the single outstanding response returns.
- Throughput: one instruction per 2 cycles minimum; bus latency adds directly.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined: in IDLE with the slot free, if pc[1:0]!=0, issue no bus request. Load fd_valid=1, fd_pc=pc, fd_instr=32'h0000_0013 (nop), fd_exc=1. Then stop issuing until a redirect. Redirects still behave as above.
- Undefined: no check is made and fd_exc is tied to 0. A misaligned pc is sent on the bus as-is.

Decomposition:
- pipes package: fetch_decode_t struct {valid, exc, pc, instr}; fetch_state_t enum {IDLE, REQ, WAIT}.
- common package: PC_RESET default constant; reuse word_t and addr_t.
- One sub-module, fetch_pcsel (combinational next-pc). Selects redirect_pc, pc+4, or pc from redirect, complete and discard.

Test Plan:
- Reset release, addr_ok and data_ok one cycle later, data 32'h00000513 -> ireq_addr=0x80000000; fd_valid=1, fd_pc=0x80000000, fd_instr=0x00000513; next ireq_addr=0x80000004.
- stall=1 held for 3 cycles while fd_valid -> no new ireq_valid; fd_pc and fd_instr unchanged. stall=0 -> request for pc+4 issued that cycle.
- Redirect to 0x80001000 while in WAIT, then data_ok with 0xDEADBEEF -> 0xDEADBEEF never appears on fd_*; next ireq_addr=0x80001000.
- Redirect in the same cycle as data_ok -> fd_valid=0 next cycle; next request is to the redirect target.
- addr_ok withheld for 4 cycles -> ireq_valid and ireq_addr stable throughout, including across a redirect raised in cycle 2.
- With FETCH_MISALIGN_EN, redirect to 0x80000002 -> no bus request; fd_valid=1, fd_exc=1, fd_instr=0x00000013.
